// File: rtl/tmr_mon_pkg.sv
// Shared types and encodings for the TMR vote monitor: FSM states,
// replica indices and stat_sel codes.
package tmr_mon_pkg;

  typedef enum logic [1:0] {
    S_CLEAN    = 2'd0,
    S_FAULTING = 2'd1,
    S_SUSPECT  = 2'd2
  } state_t;

  localparam logic [1:0] REP_A    = 2'd0;
  localparam logic [1:0] REP_B    = 2'd1;
  localparam logic [1:0] REP_C    = 2'd2;
  localparam logic [1:0] REP_NONE = 2'd3;

  localparam logic [1:0] SEL_A   = 2'd0;
  localparam logic [1:0] SEL_B   = 2'd1;
  localparam logic [1:0] SEL_C   = 2'd2;
  localparam logic [1:0] SEL_DBL = 2'd3;

  function automatic logic [1:0] popcnt3(input logic [2:0] m);
    return {1'b0, m[0]} + {1'b0, m[1]} + {1'b0, m[2]};
  endfunction

endpackage

// File: rtl/tmr_vote_monitor_voter.sv
// Combinational bitwise-majority voter with optional exclusion of one
// replica; produces the voted word and the per-replica mismatch mask.
module tmr_majority_voter
  import tmr_mon_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_rep_a,
  input  logic [WIDTH-1:0] i_rep_b,
  input  logic [WIDTH-1:0] i_rep_c,
  input  logic             i_lock_en,
  input  logic [1:0]       i_lock_id,
  output logic [WIDTH-1:0] o_voted,
  output logic [2:0]       o_mismatch
);

  logic [WIDTH-1:0] w_maj;
  logic [2:0]       w_mm;

  assign w_maj = (i_rep_a & i_rep_b) | (i_rep_a & i_rep_c) | (i_rep_b & i_rep_c);

  always_comb begin
    o_voted = w_maj;
    if (i_lock_en) begin
      case (i_lock_id)
        REP_A:   o_voted = i_rep_b;
        REP_B:   o_voted = i_rep_a;
        REP_C:   o_voted = i_rep_a;
        default: o_voted = w_maj;
      endcase
    end
  end

  // With one replica locked out, voted follows the lower survivor, so its own
  // mismatch bit must be forced when the surviving pair disagrees.
  always_comb begin
    w_mm[0] = (i_rep_a != o_voted);
    w_mm[1] = (i_rep_b != o_voted);
    w_mm[2] = (i_rep_c != o_voted);
    if (i_lock_en) begin
      case (i_lock_id)
        REP_A:   w_mm[1] = w_mm[1] | (i_rep_b != i_rep_c);
        REP_B:   w_mm[0] = w_mm[0] | (i_rep_a != i_rep_c);
        REP_C:   w_mm[0] = w_mm[0] | (i_rep_a != i_rep_b);
        default: ;
      endcase
    end
    o_mismatch = w_mm;
  end

endmodule

// File: rtl/tmr_vote_monitor.sv
// TMR vote monitor: registered majority vote, windowed per-replica mismatch
// tracking and suspect-replica flagging. TMR_MON_LOCKOUT_EN excludes the suspect from the vote.
module tmr_vote_monitor
  import tmr_mon_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned WIN_LEN    = 256,
  parameter int unsigned SUS_THRESH = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] rep_a,
  input  logic [WIDTH-1:0] rep_b,
  input  logic [WIDTH-1:0] rep_c,
  input  logic             clear_stats,
  input  logic [1:0]       stat_sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] voted,
  output logic [2:0]       fault_mask,
  output logic             fault_flag,
  output logic             sus_trojan,
  output logic [1:0]       sus_id,
  output logic             dbl_fault,
  output logic [CNT_W-1:0] stat_cnt
);

  localparam int unsigned    WW       = $clog2(WIN_LEN + 1);
  localparam logic [WW-1:0]  WIN_LAST = WW'(WIN_LEN - 1);
  localparam logic [WW-1:0]  WIN_MAX  = WW'(WIN_LEN);
  localparam logic [WW-1:0]  THRESH   = WW'(SUS_THRESH);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_voted;
  logic [2:0]       r_mask;
  logic             r_sus_trojan;
  logic [1:0]       r_sus_id;
  logic             r_dbl_fault;
  state_t           r_state;
  logic [WW-1:0]    r_win_idx;
  logic [WW-1:0]    r_win  [3];
  logic [CNT_W-1:0] r_life [4];

  logic             w_lock_en;
  logic [WIDTH-1:0] w_voted;
  logic [2:0]       w_mask;
  logic             w_win_end;
  logic [WW-1:0]    w_win_nxt [3];
  logic [2:0]       w_over;
  logic [1:0]       w_n_over;
  logic [1:0]       w_over_id;
  logic             w_set_sus;
  logic             w_dbl_smp;
  logic             w_dbl_win;
  logic [3:0]       w_life_inc;
  state_t           w_state_nxt;

`ifdef TMR_MON_LOCKOUT_EN
  assign w_lock_en = r_sus_trojan;
`else
  assign w_lock_en = 1'b0;
`endif

  tmr_majority_voter #(
    .WIDTH(WIDTH)
  ) u_voter (
    .i_rep_a    (rep_a),
    .i_rep_b    (rep_b),
    .i_rep_c    (rep_c),
    .i_lock_en  (w_lock_en),
    .i_lock_id  (r_sus_id),
    .o_voted    (w_voted),
    .o_mismatch (w_mask)
  );

  // Evaluation sees the current sample's mismatches already folded in.
  always_comb begin
    w_over = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      w_win_nxt[i] = r_win[i];
      if (w_mask[i] && (r_win[i] != WIN_MAX)) w_win_nxt[i] = r_win[i] + WW'(1);
      w_over[i] = (w_win_nxt[i] >= THRESH);
    end
  end

  assign w_win_end  = (r_win_idx == WIN_LAST);
  assign w_n_over   = popcnt3(w_over);
  assign w_over_id  = w_over[0] ? REP_A : (w_over[1] ? REP_B : REP_C);
  assign w_set_sus  = w_win_end && (w_n_over == 2'd1) && !r_sus_trojan;
  assign w_dbl_win  = w_win_end && (w_n_over >= 2'd2);
  assign w_dbl_smp  = (popcnt3(w_mask) >= 2'd2);
  assign w_life_inc = {w_dbl_smp, w_mask};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAN: begin
        if (w_set_sus)     w_state_nxt = S_SUSPECT;
        else if (|w_mask)  w_state_nxt = S_FAULTING;
      end
      S_FAULTING: begin
        if (w_set_sus)                              w_state_nxt = S_SUSPECT;
        else if (w_win_end && (w_n_over == 2'd0))   w_state_nxt = S_CLEAN;
      end
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_voted      <= '0;
      r_mask       <= '0;
      r_sus_trojan <= 1'b0;
      r_sus_id     <= REP_NONE;
      r_dbl_fault  <= 1'b0;
      r_state      <= S_CLEAN;
      r_win_idx    <= '0;
      for (int unsigned i = 0; i < 3; i++) r_win[i] <= '0;
      for (int unsigned i = 0; i < 4; i++) r_life[i] <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_voted <= w_voted;
        r_mask  <= w_mask;
      end
      // A coincident sample is still output above but never counted.
      if (clear_stats) begin
        r_sus_trojan <= 1'b0;
        r_sus_id     <= REP_NONE;
        r_dbl_fault  <= 1'b0;
        r_state      <= S_CLEAN;
        r_win_idx    <= '0;
        for (int unsigned i = 0; i < 3; i++) r_win[i] <= '0;
        for (int unsigned i = 0; i < 4; i++) r_life[i] <= '0;
      end else if (in_valid) begin
        r_win_idx <= w_win_end ? '0 : r_win_idx + WW'(1);
        for (int unsigned i = 0; i < 3; i++) r_win[i] <= w_win_end ? '0 : w_win_nxt[i];
        for (int unsigned i = 0; i < 4; i++) begin
          if (w_life_inc[i] && (r_life[i] != '1)) r_life[i] <= r_life[i] + CNT_W'(1);
        end
        if (w_set_sus) begin
          r_sus_trojan <= 1'b1;
          r_sus_id     <= w_over_id;
        end
        if (w_dbl_smp || w_dbl_win) r_dbl_fault <= 1'b1;
        r_state <= w_state_nxt;
      end
    end
  end

  always_comb begin
    case (stat_sel)
      SEL_A:   stat_cnt = r_life[0];
      SEL_B:   stat_cnt = r_life[1];
      SEL_C:   stat_cnt = r_life[2];
      SEL_DBL: stat_cnt = r_life[3];
      default: stat_cnt = '0;
    endcase
  end

  assign out_valid  = r_out_valid;
  assign voted      = r_voted;
  assign fault_mask = r_mask;
  assign fault_flag = |r_mask;
  assign sus_trojan = r_sus_trojan;
  assign sus_id     = r_sus_id;
  assign dbl_fault  = r_dbl_fault;

endmodule
